fifo_uart_tx: RTL and testbench

//  Read-side consumer for the byte FIFO: pops bytes through the FIFO's read

---
 rtl/fifo_uart_tx.sv | 133 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO through its ready/okuma_cs read handshake and
// serializes each popped byte as a UART frame: start, 8 data bits LSB first, optional parity, stop.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter bit PARITY_EN    = 1'b0,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       fifo_ready,
   input  logic [7:0] fifo_data,
   output logic       fifo_okuma_cs,
   output logic       tx,
   output logic       busy,
   output logic       byte_done
);
   // state  | meaning
   // IDLE   | line high, waiting for enable & fifo_ready
   // START  | start bit (0) on the line
   // DATA   | data bit shift_reg[bit_idx], bit_idx 0..7
   // PARITY | parity bit (only reachable when PARITY_EN=1)
   // STOP   | stop bit (1); last cycle may pop the next byte

   localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift_reg;
   logic          parity_bit;
   logic          bit_end;
   logic          take;

   // Bit-time down-counter: a state ends when it reaches zero.
   assign bit_end = (cnt == '0);

   // Gated by rst so the FIFO never sees a pop while the block is held in reset.
   assign take = rst & enable & fifo_ready &
                 ((state == IDLE) | ((state == STOP) & bit_end));
   assign fifo_okuma_cs = take;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         byte_done  <= 1'b0;
      end else begin
         byte_done <= 1'b0;
         if (take) begin
            shift_reg  <= fifo_data;
            parity_bit <= PARITY_ODD ? ~^fifo_data : ^fifo_data;
            state      <= START;
            cnt        <= CNT_LOAD;
            bit_idx    <= '0;
            tx         <= 1'b0;
            busy       <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  tx   <= 1'b1;
                  busy <= 1'b0;
               end
               START: begin
                  if (bit_end) begin
                     state <= DATA;
                     cnt   <= CNT_LOAD;
                     tx    <= shift_reg[0];
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end
               DATA: begin
                  if (bit_end) begin
                     cnt <= CNT_LOAD;
                     if (bit_idx == 3'd7) begin
                        if (PARITY_EN) begin
                           state <= PARITY;
                           tx    <= parity_bit;
                        end else begin
                           state <= STOP;
                           tx    <= 1'b1;
                        end
                     end else begin
                        bit_idx <= bit_idx + 3'd1;
                        tx      <= shift_reg[bit_idx + 3'd1];
                     end
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end
               PARITY: begin
                  if (bit_end) begin
                     state <= STOP;
                     cnt   <= CNT_LOAD;
                     tx    <= 1'b1;
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end
               STOP: begin
                  // Set one cycle early so the registered pulse lands on the last stop cycle.
                  if (cnt == CNT_ONE) begin
                     byte_done <= 1'b1;
                  end
                  if (bit_end) begin
                     state <= IDLE;
                     tx    <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end
               default: begin
                  state <= IDLE;
                  tx    <= 1'b1;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model + frame-decoding scoreboard on the main instance,
// table-driven per-cycle frame checks, and two parity-enabled instances.
module tb_fifo_uart_tx;
   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       fifo_ready;
   logic [7:0] fifo_data;
   logic       okuma, tx, busy, byte_done;

   logic       p_en, p_ready;
   logic [7:0] p_data;
   logic       okuma_o, tx_o, busy_o, bd_o;
   logic       okuma_e, tx_e, busy_e, bd_e;

   always #5 clk = ~clk;

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
      .clk(clk), .rst(rst), .enable(enable), .fifo_ready(fifo_ready), .fifo_data(fifo_data),
      .fifo_okuma_cs(okuma), .tx(tx), .busy(busy), .byte_done(byte_done));

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_odd (
      .clk(clk), .rst(rst), .enable(p_en), .fifo_ready(p_ready), .fifo_data(p_data),
      .fifo_okuma_cs(okuma_o), .tx(tx_o), .busy(busy_o), .byte_done(bd_o));

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_even (
      .clk(clk), .rst(rst), .enable(p_en), .fifo_ready(p_ready), .fifo_data(p_data),
      .fifo_okuma_cs(okuma_e), .tx(tx_e), .busy(busy_e), .byte_done(bd_e));

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int pop_cnt = 0;
   int frames_rx = 0;
   logic [7:0] fifo_q[$];
   logic [7:0] exp_q[$];
   int         pop_cyc[$];
   logic       pend;

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
   } vec_t;

   typedef struct {
      logic [7:0]  data;
      logic [10:0] f_odd;
      logic [10:0] f_even;
   } pvec_t;

   vec_t  vecs[5];
   pvec_t pvecs[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fifo_upd();
      fifo_ready = (fifo_q.size() != 0);
      fifo_data  = fifo_ready ? fifo_q[0] : 8'h00;
   endtask

   task automatic push(input logic [7:0] d);
      fifo_q.push_back(d);
      fifo_upd();
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // FIFO model: a strobe seen mid-cycle pops the head just after the next posedge.
   always begin
      @(negedge clk);
      pend = okuma;
      if (okuma === 1'b1) chk("okuma_only_when_ready", fifo_ready, 1'b1);
      @(posedge clk);
      #1;
      if (pend === 1'b1 && fifo_q.size() != 0) begin
         exp_q.push_back(fifo_q.pop_front());
         pop_cyc.push_back(cyc);
         pop_cnt++;
         fifo_upd();
      end
   end

   // Line monitor: decodes frames at bit centres and scores them against popped bytes.
   logic [7:0] m_rx;
   logic       m_start, m_stop;
   int         m_bd, m_busy;
   bit         m_ab;
   always begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
         m_rx = 8'h00; m_bd = 0; m_busy = 0; m_ab = 1'b0; m_start = 1'b1; m_stop = 1'b0;
         for (int t = 0; t < 40; t++) begin
            if (t > 0) @(negedge clk);
            if (rst !== 1'b1) begin
               m_ab = 1'b1;
               break;
            end
            if (t == 2) m_start = tx;
            if (t >= 6 && t <= 34 && (t % 4) == 2) m_rx = {tx, m_rx[7:1]};
            if (t == 38) m_stop = tx;
            if (byte_done !== (t == 39)) m_bd++;
            if (busy !== 1'b1) m_busy++;
         end
         if (!m_ab) begin
            chk("rx_start_bit", m_start, 1'b0);
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL rx_unexpected_frame: got 0x%02h, expected no frame", m_rx);
            end else begin
               chk("rx_data", m_rx, exp_q.pop_front());
            end
            chk("rx_stop_bit", m_stop, 1'b1);
            chk("rx_byte_done_timing_errs", m_bd, 0);
            chk("rx_busy_drop_errs", m_busy, 0);
            frames_rx++;
         end
      end
   end

   task automatic send_check(input logic [7:0] d, input logic [9:0] frame);
      int base, e_tx, e_bd, e_busy;
      logic exp_tx;
      base = pop_cnt; e_tx = 0; e_bd = 0; e_busy = 0;
      @(posedge clk); #2;
      push(d);
      @(negedge clk);
      chk($sformatf("tbl_%02h_okuma_pop_cycle", d), okuma, 1'b1);
      for (int c = 1; c <= 41; c++) begin
         @(negedge clk);
         exp_tx = (c <= 40) ? frame[(c - 1) / 4] : 1'b1;
         if (tx !== exp_tx) e_tx++;
         if (byte_done !== (c == 40)) e_bd++;
         if (busy !== (c <= 40)) e_busy++;
      end
      chk($sformatf("tbl_%02h_tx_errs", d), e_tx, 0);
      chk($sformatf("tbl_%02h_byte_done_errs", d), e_bd, 0);
      chk($sformatf("tbl_%02h_busy_errs", d), e_busy, 0);
      chk($sformatf("tbl_%02h_pop_count", d), pop_cnt - base, 1);
   endtask

   task automatic wait_pops(input int base, input int n, input string name);
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (pop_cnt - base >= n) break;
      end
      chk(name, pop_cnt - base, n);
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, qb, errs, drop, bdc, f0;
      logic eo, ee;

      vecs[0] = '{8'hA5, 10'b1101001010};
      vecs[1] = '{8'h00, 10'b1000000000};
      vecs[2] = '{8'hFF, 10'b1111111110};
      vecs[3] = '{8'h3C, 10'b1001111000};
      vecs[4] = '{8'h81, 10'b1100000010};
      pvecs[0] = '{8'h07, 11'b10000001110, 11'b11000001110};
      pvecs[1] = '{8'h00, 11'b11000000000, 11'b10000000000};

      // Reset with a byte waiting: no strobe may escape while rst is low.
      rst = 1'b0; enable = 1'b1; p_en = 1'b1; p_ready = 1'b0; p_data = 8'h00;
      push(8'h11);
      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_byte_done", byte_done, 1'b0);
      chk("rst_okuma", okuma, 1'b0);
      chk("rst_tx_parity_dut", tx_o, 1'b1);
      fifo_q.delete();
      fifo_upd();
      @(posedge clk); #2;
      rst = 1'b1;

      // Empty FIFO for 100 clocks.
      errs = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (okuma !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) errs++;
      end
      chk("empty_idle_errs", errs, 0);
      chk("empty_no_pop", pop_cnt, 0);

      for (int i = 0; i < 5; i++) send_check(vecs[i].data, vecs[i].frame);

      // Three queued bytes go out back to back.
      base = pop_cnt; qb = pop_cyc.size(); drop = 0; bdc = 0;
      @(posedge clk); #2;
      push(8'h00); push(8'hFF); push(8'h3C);
      @(negedge clk);
      chk("b2b_first_okuma", okuma, 1'b1);
      for (int c = 1; c <= 120; c++) begin
         @(negedge clk);
         if (busy !== 1'b1) drop++;
         if (byte_done === 1'b1) bdc++;
      end
      @(negedge clk);
      chk("b2b_busy_after", busy, 1'b0);
      chk("b2b_busy_drops", drop, 0);
      chk("b2b_byte_done_count", bdc, 3);
      chk("b2b_pop_count", pop_cnt - base, 3);
      if (pop_cyc.size() - qb == 3) begin
         chk("b2b_pop_gap1", pop_cyc[qb + 1] - pop_cyc[qb], 40);
         chk("b2b_pop_gap2", pop_cyc[qb + 2] - pop_cyc[qb + 1], 40);
      end

      // enable dropped 10 clocks into a frame with more data waiting.
      base = pop_cnt; errs = 0;
      @(posedge clk); #2;
      push(8'h5A); push(8'hC3);
      repeat (10) @(posedge clk);
      #2 enable = 1'b0;
      for (int c = 10; c <= 80; c++) begin
         @(negedge clk);
         if (c > 40 && (tx !== 1'b1 || busy !== 1'b0 || okuma !== 1'b0)) errs++;
      end
      chk("en_off_idle_errs", errs, 0);
      chk("en_off_single_pop", pop_cnt - base, 1);
      @(posedge clk); #2;
      enable = 1'b1;
      wait_pops(base, 2, "en_resume_pop");
      repeat (45) @(negedge clk);
      chk("en_resume_done_busy", busy, 1'b0);

      // Reset in the middle of data bit 3.
      base = pop_cnt; f0 = frames_rx;
      @(posedge clk); #2;
      push(8'h96); push(8'h3C);
      repeat (18) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midrst_tx", tx, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      exp_q.delete();
      @(negedge clk);
      chk("midrst_okuma", okuma, 1'b0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      wait_pops(base, 2, "midrst_next_pop");
      repeat (45) @(negedge clk);
      chk("midrst_frames", frames_rx - f0, 1);
      chk("midrst_busy_after", busy, 1'b0);

      // Parity instances: 11-bit frames, odd and even sense side by side.
      for (int i = 0; i < 2; i++) begin
         errs = 0;
         @(posedge clk); #2;
         p_data = pvecs[i].data; p_ready = 1'b1;
         @(negedge clk);
         chk($sformatf("par_%02h_okuma_odd", pvecs[i].data), okuma_o, 1'b1);
         chk($sformatf("par_%02h_okuma_even", pvecs[i].data), okuma_e, 1'b1);
         @(posedge clk); #2;
         p_ready = 1'b0; p_data = 8'hEE;
         for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            eo = (c <= 44) ? pvecs[i].f_odd[(c - 1) / 4] : 1'b1;
            ee = (c <= 44) ? pvecs[i].f_even[(c - 1) / 4] : 1'b1;
            if (tx_o !== eo || tx_e !== ee) errs++;
            if (bd_o !== (c == 44) || bd_e !== (c == 44)) errs++;
            if (busy_o !== (c <= 44) || busy_e !== (c <= 44)) errs++;
         end
         chk($sformatf("par_%02h_frame_errs", pvecs[i].data), errs, 0);
      end

      for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
